// File: rtl/log2_pkg.sv
// Definitions shared by the normalize and denormalize stages of the log2/exp2 datapath.
package log2_pkg;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } round_mode_e;

  // Norm-count width; the shifter also uses one stage per norm bit.
  function automatic int unsigned norm_width(input int unsigned width);
    return $clog2(width);
  endfunction

  function automatic logic rne_increment(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/denormalize_if.sv
// Valid/ready stream bundle for denormalize: input beat {data, norm} and output beat {data}.
interface denormalize_if
  import log2_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NORM_W = norm_width(WIDTH)
);
  logic [WIDTH-1:0]  data_i;
  logic [NORM_W-1:0] norm_i;
  logic              valid_i;
  logic              ready_o;
  logic [WIDTH-1:0]  data_o;
  logic              valid_o;
  logic              ready_i;

  modport slave (
    input  data_i, norm_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  modport master (
    output data_i, norm_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );
endinterface

// File: rtl/denorm_stage.sv
// One registered conditional right shift by 2**SHIFT_BIT with guard/sticky tracking.
module denorm_stage
  import log2_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NORM_W    = norm_width(WIDTH),
  parameter int unsigned SHIFT_BIT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_guard,
  input  logic              i_sticky,
  input  logic [NORM_W-1:0] i_norm,
  input  logic              i_valid,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_guard,
  output logic              o_sticky,
  output logic [NORM_W-1:0] o_norm,
  output logic              o_valid
);
  localparam int unsigned K = 1 << SHIFT_BIT;

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic              guard;
    logic              sticky;
    logic [NORM_W-1:0] norm;
    logic              valid;
  } stage_t;

  stage_t w_next;
  stage_t r_stage;

  // Bits at or above K land in the result, bit K-1 becomes guard, the rest fold into sticky.
  always_comb begin
    w_next.data   = i_data;
    w_next.guard  = i_guard;
    w_next.sticky = i_sticky;
    w_next.norm   = i_norm;
    w_next.valid  = i_valid;
    if (i_norm[SHIFT_BIT]) begin
      w_next.data   = '0;
      w_next.guard  = 1'b0;
      w_next.sticky = i_sticky | i_guard;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (j >= K)
          w_next.data[j-K] = i_data[j];
        else if (j == K - 1)
          w_next.guard = i_data[j];
        else
          w_next.sticky = w_next.sticky | i_data[j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_stage <= '0;
    else if (i_load)
      r_stage <= w_next;
  end

  assign o_data   = r_stage.data;
  assign o_guard  = r_stage.guard;
  assign o_sticky = r_stage.sticky;
  assign o_norm   = r_stage.norm;
  assign o_valid  = r_stage.valid;

endmodule

// File: rtl/denormalize.sv
// Pipelined right shift by a norm count with truncate or round-to-nearest-even output.
module denormalize
  import log2_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter round_mode_e ROUND_MODE = RND_RNE
) (
  input  logic         clock,
  input  logic         reset,
  denormalize_if.slave bus
);
  localparam int unsigned NORM_W = norm_width(WIDTH);
  localparam int unsigned STEPS  = NORM_W;

  // Index 0 is the input beat; index n+1 is the register of shift stage n.
  logic [WIDTH-1:0]  w_data   [STEPS+1];
  logic              w_guard  [STEPS+1];
  logic              w_sticky [STEPS+1];
  logic [NORM_W-1:0] w_norm   [STEPS+1];
  logic              w_valid  [STEPS+1];
  logic              w_load   [STEPS+1];

  logic              w_round_inc;
  logic [WIDTH-1:0]  w_round_data;
  logic              w_unused;
  logic [WIDTH-1:0]  r_data_o;
  logic              r_valid_o;

  assign w_data[0]   = bus.data_i;
  assign w_guard[0]  = 1'b0;
  assign w_sticky[0] = 1'b0;
  assign w_norm[0]   = bus.norm_i;
  assign w_valid[0]  = bus.valid_i;

  // Largest shift first, mirroring the normalize stage.
  for (genvar n = 0; n < STEPS; n++) begin : g_shift
    denorm_stage #(
      .WIDTH     (WIDTH),
      .NORM_W    (NORM_W),
      .SHIFT_BIT (STEPS - n - 1)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_load[n]),
      .i_data   (w_data[n]),
      .i_guard  (w_guard[n]),
      .i_sticky (w_sticky[n]),
      .i_norm   (w_norm[n]),
      .i_valid  (w_valid[n]),
      .o_data   (w_data[n+1]),
      .o_guard  (w_guard[n+1]),
      .o_sticky (w_sticky[n+1]),
      .o_norm   (w_norm[n+1]),
      .o_valid  (w_valid[n+1])
    );

    assign w_load[n] = ~w_valid[n+1] | w_load[n+1];
  end

  assign w_load[STEPS] = ~r_valid_o | bus.ready_i;
  assign bus.ready_o   = w_load[0];

  // Any shift of at least one clears the MSB, so the increment cannot overflow.
  always_comb begin
    w_round_inc = 1'b0;
    if (ROUND_MODE == RND_RNE)
      w_round_inc = rne_increment(w_guard[STEPS], w_sticky[STEPS], w_data[STEPS][0]);
  end

  assign w_round_data = w_data[STEPS] + WIDTH'(w_round_inc);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else if (w_load[STEPS]) begin
      r_data_o  <= w_round_data;
      r_valid_o <= w_valid[STEPS];
    end
  end

  assign bus.data_o  = r_data_o;
  assign bus.valid_o = r_valid_o;

  assign w_unused = ^w_norm[STEPS];

endmodule

// File: tb/tb_denormalize.sv
// Bench for denormalize: 16-bit RNE and truncate instances fed in lockstep, plus a 5-bit RNE instance.
module tb_denormalize;
  import log2_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  denormalize_if #(.WIDTH(16)) bus_r ();
  denormalize_if #(.WIDTH(16)) bus_t ();
  denormalize_if #(.WIDTH(5))  bus_5 ();

  denormalize #(.WIDTH(16), .ROUND_MODE(RND_RNE))   u_rne (.clock(clock), .reset(reset), .bus(bus_r));
  denormalize #(.WIDTH(16), .ROUND_MODE(RND_TRUNC)) u_trn (.clock(clock), .reset(reset), .bus(bus_t));
  denormalize #(.WIDTH(5),  .ROUND_MODE(RND_RNE))   u_w5  (.clock(clock), .reset(reset), .bus(bus_5));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  int unsigned out_r    = 0;
  int unsigned out_t    = 0;
  int unsigned out_5    = 0;
  longint      q_r[$];
  longint      q_t[$];
  longint      q_5[$];

  // Exact quotient x / 2**n, optionally rounded to nearest with ties to even.
  function automatic longint ref_div(input longint x, input int unsigned n, input bit rne);
    longint p, q, r;
    p = longint'(1) << n;
    q = x / p;
    r = x % p;
    if (!rne || n == 0) return q;
    if (2 * r > p) return q + 1;
    if (2 * r == p) return q + (q % 2);
    return q;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: capture accepted inputs and compare delivered outputs in order.
  always @(negedge clock) begin
    if (reset) begin
      q_r.delete();
      q_t.delete();
      q_5.delete();
    end else begin
      if (bus_r.valid_i && bus_r.ready_o) q_r.push_back(ref_div(longint'(bus_r.data_i), bus_r.norm_i, 1'b1));
      if (bus_t.valid_i && bus_t.ready_o) q_t.push_back(ref_div(longint'(bus_t.data_i), bus_t.norm_i, 1'b0));
      if (bus_5.valid_i && bus_5.ready_o) q_5.push_back(ref_div(longint'(bus_5.data_i), bus_5.norm_i, 1'b1));
      if (bus_r.valid_o && bus_r.ready_i) begin
        out_r++;
        check("rne_no_x", 64'($isunknown(bus_r.data_o)), 0);
        check("rne_queued", 64'(q_r.size() > 0), 1);
        if (q_r.size() > 0) check("rne_data", bus_r.data_o, q_r.pop_front());
      end
      if (bus_t.valid_o && bus_t.ready_i) begin
        out_t++;
        check("trn_no_x", 64'($isunknown(bus_t.data_o)), 0);
        check("trn_queued", 64'(q_t.size() > 0), 1);
        if (q_t.size() > 0) check("trn_data", bus_t.data_o, q_t.pop_front());
      end
      if (bus_5.valid_o && bus_5.ready_i) begin
        out_5++;
        check("w5_no_x", 64'($isunknown(bus_5.data_o)), 0);
        check("w5_queued", 64'(q_5.size() > 0), 1);
        if (q_5.size() > 0) check("w5_data", bus_5.data_o, q_5.pop_front());
      end
    end
  end

  task automatic set16(input logic v, input logic [15:0] d, input logic [3:0] n);
    bus_r.valid_i = v; bus_r.data_i = d; bus_r.norm_i = n;
    bus_t.valid_i = v; bus_t.data_i = d; bus_t.norm_i = n;
  endtask

  task automatic rdy16(input logic r);
    bus_r.ready_i = r;
    bus_t.ready_i = r;
  endtask

  task automatic set5(input logic v, input logic [4:0] d, input logic [2:0] n);
    bus_5.valid_i = v; bus_5.data_i = d; bus_5.norm_i = n;
  endtask

  task automatic directed16(input logic [15:0] d, input logic [3:0] n,
                            input logic [15:0] er, input logic [15:0] et);
    int unsigned lat;
    lat = 1;
    set16(1'b1, d, n);
    #1;
    check("direct16_ready", bus_r.ready_o, 1);
    @(posedge clock); #1;
    set16(1'b0, '0, '0);
    while (!bus_r.valid_o && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency16", lat, 5);
    check("direct16_rne", bus_r.data_o, er);
    check("direct16_trn", bus_t.data_o, et);
    @(posedge clock); #1;
  endtask

  task automatic directed5(input logic [4:0] d, input logic [2:0] n, input logic [4:0] e);
    int unsigned lat;
    lat = 1;
    set5(1'b1, d, n);
    @(posedge clock); #1;
    set5(1'b0, '0, '0);
    while (!bus_5.valid_o && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency5", lat, 4);
    check("direct5", bus_5.data_o, e);
    @(posedge clock); #1;
  endtask

  initial begin
    int unsigned acc, cyc, stalls, base;
    logic [15:0] x, y, snap;
    logic [3:0]  lz;
    logic [15:0] bp [8];
    bit          have, snap_ok;

    set16(1'b0, '0, '0);
    rdy16(1'b1);
    set5(1'b0, '0, '0);
    bus_5.ready_i = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_valid_o", bus_r.valid_o, 0);
    check("rst_data_o", bus_r.data_o, 0);
    check("rst_ready_o", bus_r.ready_o, 1);
    check("rst_trn_valid_o", bus_t.valid_o, 0);
    check("rst_w5_ready_o", bus_5.ready_o, 1);

    directed16(16'h8000, 4'd15, 16'h0001, 16'h0001);
    directed16(16'hFFFF, 4'd0,  16'hFFFF, 16'hFFFF);
    directed16(16'hC000, 4'd15, 16'h0002, 16'h0001);
    directed16(16'hA000, 4'd14, 16'h0002, 16'h0002);
    directed16(16'hE000, 4'd14, 16'h0004, 16'h0003);
    directed16(16'hA001, 4'd14, 16'h0003, 16'h0002);
    directed16(16'h0000, 4'd7,  16'h0000, 16'h0000);
    directed16(16'h7FFF, 4'd15, 16'h0001, 16'h0000);

    // Norm counts at and beyond the 5-bit width.
    directed5(5'd31, 3'd5, 5'd1);
    directed5(5'd16, 3'd5, 5'd0);
    directed5(5'd24, 3'd5, 5'd1);
    directed5(5'd17, 3'd5, 5'd1);
    directed5(5'd31, 3'd7, 5'd0);
    directed5(5'd24, 3'd4, 5'd2);
    directed5(5'd31, 3'd0, 5'd31);

    // Round trip: normalize x, then shift back; the truncating instance must return x.
    rdy16(1'b1);
    stalls = 0;
    base = out_t;
    for (int i = 0; i < 10000; i++) begin
      x = 16'($urandom_range(1, 65535));
      y = x;
      lz = '0;
      while (!y[15]) begin
        y = y << 1;
        lz++;
      end
      set16(1'b1, y, lz);
      #1;
      if (!bus_t.ready_o) stalls++;
      @(posedge clock); #1;
    end
    set16(1'b0, '0, '0);
    repeat (8) @(posedge clock);
    #1;
    check("rt_stalls", stalls, 0);
    check("rt_count", out_t - base, 10000);

    // Backpressure: downstream stalled for 10 cycles while 8 beats are offered.
    for (int i = 0; i < 8; i++) bp[i] = 16'($urandom);
    rdy16(1'b0);
    acc = 0;
    snap_ok = 0;
    snap = '0;
    base = out_r;
    for (int c = 0; c < 10; c++) begin
      set16(1'b1, bp[acc], 4'(acc + 1));
      #1;
      if (bus_r.ready_o) acc++;
      @(posedge clock); #1;
      if (bus_r.valid_o) begin
        if (snap_ok) check("bp_stable", bus_r.data_o, snap);
        snap = bus_r.data_o;
        snap_ok = 1;
      end
    end
    check("bp_held", acc, 5);
    check("bp_ready_low", bus_r.ready_o, 0);
    check("bp_no_out", out_r - base, 0);
    rdy16(1'b1);
    cyc = 0;
    while (acc < 8 && cyc < 50) begin
      set16(1'b1, bp[acc], 4'(acc + 1));
      #1;
      if (bus_r.ready_o) acc++;
      @(posedge clock); #1;
      cyc++;
    end
    set16(1'b0, '0, '0);
    repeat (10) @(posedge clock);
    #1;
    check("bp_accepted", acc, 8);
    check("bp_delivered", out_r - base, 8);

    // Random valid/ready at 50% each.
    acc = 0;
    cyc = 0;
    have = 0;
    while (acc < 5000 && cyc < 40000) begin
      rdy16(1'($urandom_range(0, 1)));
      if (!have && $urandom_range(0, 1) == 1) begin
        set16(1'b1, 16'($urandom), 4'($urandom_range(0, 15)));
        have = 1;
      end else if (!have) begin
        set16(1'b0, '0, '0);
      end
      #1;
      if (have && bus_r.ready_o) begin
        acc++;
        have = 0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    set16(1'b0, '0, '0);
    rdy16(1'b1);
    repeat (8) @(posedge clock);
    #1;
    check("rand_beats", acc, 5000);
    check("rand_rne_drained", q_r.size(), 0);
    check("rand_trn_drained", q_t.size(), 0);

    // Random traffic on the 5-bit instance, norm up to 7.
    acc = 0;
    cyc = 0;
    have = 0;
    while (acc < 500 && cyc < 5000) begin
      bus_5.ready_i = 1'($urandom_range(0, 1));
      if (!have && $urandom_range(0, 1) == 1) begin
        set5(1'b1, 5'($urandom), 3'($urandom_range(0, 7)));
        have = 1;
      end else if (!have) begin
        set5(1'b0, '0, '0);
      end
      #1;
      if (have && bus_5.ready_o) begin
        acc++;
        have = 0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    set5(1'b0, '0, '0);
    bus_5.ready_i = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("w5_rand_beats", acc, 500);
    check("w5_drained", q_5.size(), 0);

    // Reset with three beats in flight.
    rdy16(1'b1);
    for (int i = 0; i < 3; i++) begin
      set16(1'b1, 16'($urandom), 4'($urandom_range(1, 15)));
      @(posedge clock); #1;
    end
    set16(1'b0, '0, '0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst2_valid_o", bus_r.valid_o, 0);
    check("rst2_data_o", bus_r.data_o, 0);
    check("rst2_ready_o", bus_r.ready_o, 1);
    check("rst2_trn_valid_o", bus_t.valid_o, 0);
    base = out_r;
    repeat (12) @(posedge clock);
    #1;
    check("rst2_no_stale", out_r - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
